// File: rtl/cpu_pkg.sv
// Shared CPU constants: widths, opcode field position and fetch FSM state encodings.
package cpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned OP_LSB = DATA_W - OP_W;

  localparam logic [OP_W-1:0]   HALT_OP   = 4'hF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t StIdle = 3'd0;
  localparam fetch_state_t StStep = 3'd1;
  localparam fetch_state_t StRead = 3'd2;
  localparam fetch_state_t StOut  = 3'd3;
  localparam fetch_state_t StHalt = 3'd4;

  function automatic logic is_halt_op(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: OP_W] == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port, one registered read port.
module instr_mem
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rdata_q;

  // The array itself is never reset so a program survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch controller: steps the program counter, reads the store and hands
// instructions to decode over valid/ready until a HALT opcode or the last address.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              busy
);

  fetch_state_t state_q, state_d;
  logic         mem_we;
  logic         mem_re;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StStep;
      StStep: state_d = StRead;
      StRead: state_d = StOut;
      StOut: begin
        // The counter still holds this instruction's address, so no wrap past the end.
        if (instr_ready) begin
          state_d = (is_halt_op(instr) || (pc == LAST_ADDR)) ? StHalt : StStep;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_we = res && (state_q == StIdle) && load_en;
  assign mem_re = (state_q == StRead);

  instr_mem u_instr_mem (
    .clk   (clk),
    .res   (res),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc),
    .rdata (instr)
  );

  // Outputs decode the registered state only; no input reaches them combinationally.
  assign pc_en       = (state_q == StStep);
  assign instr_valid = (state_q == StOut);
  assign halted      = (state_q == StHalt);
  assign busy        = (state_q == StStep) || (state_q == StRead) || (state_q == StOut);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural program counter.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = 6'd0;
  logic [15:0] load_data = 16'd0;
  logic        start = 1'b0;
  logic        instr_ready = 1'b0;
  logic [5:0]  pc;
  logic        pc_en;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [15:0] got [$];

  instr_fetch dut (
    .clk         (clk),
    .res         (res),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .pc          (pc),
    .pc_en       (pc_en),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Program counter model: resets to 63, so the first step yields address 0.
  always @(posedge clk) begin
    if (!res) pc <= 6'd63;
    else if (pc_en) pc <= pc + 6'd1;
  end

  always @(posedge clk) begin
    if (res && pc_en) pulses <= pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ld;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        st;
    logic        e_pc_en;
    logic        e_valid;
    logic [15:0] e_instr;
    logic        e_halted;
    logic        e_busy;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    res = 1'b0;
    tick();
    res = 1'b1;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [15:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Runs from IDLE with ready high, collecting every accepted instruction.
  task automatic run_prog(input int max_cycles, input bit load_busy);
    got.delete();
    start = 1'b1;
    instr_ready = 1'b1;
    tick();
    start = 1'b0;
    if (load_busy) begin
      load_en = 1'b1;
      load_addr = 6'd5;
      load_data = 16'hBEEF;
    end
    for (int i = 0; i < max_cycles && !halted; i++) begin
      if (instr_valid) got.push_back(instr);
      tick();
    end
    load_en = 1'b0;
    check("run_halts", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int p0;
    int nerr;

    vt[0]  = '{1'b1, 6'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 6'd1, 16'h2345, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 6'd2, 16'hF000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 6'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h2345, 1'b0, 1'b1};
    vt[10] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b1};
    vt[11] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b1};
    vt[12] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF000, 1'b1, 1'b0};
    vt[13] = '{1'b1, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hF000, 1'b1, 1'b0};

    tick();
    do_reset();
    check("reset_state", {12'd0, pc_en, instr_valid, instr, halted, busy}, 32'd0);

    // Basic program, cycle by cycle.
    p0 = pulses;
    instr_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      load_en = vt[i].ld;
      load_addr = vt[i].addr;
      load_data = vt[i].data;
      start = vt[i].st;
      tick();
      check($sformatf("vec%0d", i), {12'd0, pc_en, instr_valid, instr, halted, busy},
            {12'd0, vt[i].e_pc_en, vt[i].e_valid, vt[i].e_instr, vt[i].e_halted, vt[i].e_busy});
    end
    load_en = 1'b0;
    start = 1'b0;
    check("basic_pc", {26'd0, pc}, 32'd2);
    check("basic_pulses", pulses - p0, 32'd3);

    // Backpressure; program retained across reset, HALT-state write ignored.
    do_reset();
    check("reset_after_halt", {12'd0, pc_en, instr_valid, instr, halted, busy}, 32'd0);
    p0 = pulses;
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("bp_first", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h1234});
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {14'd0, pc_en, instr_valid, instr},
            {14'd0, 1'b0, 1'b1, 16'h1234});
    end
    check("bp_no_pulse", pulses - p0, 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_h0", {31'd0, instr_valid}, 32'd0);
    tick();
    check("bp_h1", {31'd0, instr_valid}, 32'd0);
    tick();
    check("bp_h2", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h2345});

    // Load while busy must not alter mem[5].
    do_reset();
    for (int i = 0; i < 6; i++) load_word(6'(i), 16'h1000 + 16'(i));
    load_word(6'd6, 16'hF000);
    run_prog(100, 1'b1);
    check("busy_count", got.size(), 32'd7);
    check("busy_mem5", {16'd0, (got.size() > 5) ? got[5] : 16'h0000}, 32'h1005);
    do_reset();
    run_prog(100, 1'b0);
    check("busy_mem5_refetch", {16'd0, (got.size() > 5) ? got[5] : 16'h0000}, 32'h1005);

    // End of memory: all non-HALT words, stop after address 63.
    do_reset();
    for (int i = 0; i < 64; i++) load_word(6'(i), 16'h0100 + 16'(i));
    p0 = pulses;
    run_prog(400, 1'b0);
    check("eom_count", got.size(), 32'd64);
    nerr = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 16'h0100 + 16'(i)) nerr++;
    check("eom_data", nerr, 32'd0);
    check("eom_pulses", pulses - p0, 32'd64);
    start = 1'b1;
    load_en = 1'b1;
    tick();
    tick();
    start = 1'b0;
    load_en = 1'b0;
    check("eom_stuck", {25'd0, halted, pc}, {25'd0, 1'b1, 6'd63});

    // Reset while an instruction is pending.
    do_reset();
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_pending", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h0100});
    res = 1'b0;
    tick();
    res = 1'b1;
    check("mid_reset", {12'd0, pc_en, instr_valid, instr, halted, busy}, 32'd0);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_mem_intact", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h0100});

    // Same-cycle load and start.
    do_reset();
    load_en = 1'b1;
    load_addr = 6'd0;
    load_data = 16'hABCD;
    start = 1'b1;
    tick();
    load_en = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("same_cycle", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'hABCD});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch controller: the consumer end of the `program_counter` interface. Holds a 64-entry instruction store, drives the counter's enable, reads the instruction at the counter's current address, and presents it to decode with a valid/ready handshake. It stops the program on a HALT opcode or at the last address.

## Interface
- `ADDR_W`, 6: address width; must match the program counter output width.
- `DATA_W`, 16: instruction width.
- `HALT_OP`, 4'hF: opcode in `instr[DATA_W-1:DATA_W-4]` that halts fetch.
- `clk  in  1`: single clock; all state updates on rising edge.
- `res  in  1`: reset, synchronous, active-low.
- `load_en  in  1`: program-store write strobe; honoured in IDLE only.
- `load_addr  in  ADDR_W`: write address.
- `load_data  in  DATA_W`: write data.
- `start  in  1`: begin execution; honoured in IDLE only.
- `pc  in  ADDR_W`: current program counter value.
- `pc_en  out  1`: enable to the program counter.
- `instr  out  DATA_W`: fetched instruction.
- `instr_valid  out  1`: `instr` valid.
- `instr_ready  in  1`: decode accepts `instr`.
- `halted  out  1`: program finished; sticky until reset.
- `busy  out  1`: high in any state other than IDLE and HALT.

## Operation
- States: IDLE, STEP, READ, OUT, HALT.
- IDLE: `pc_en`=0. `load_en`=1 writes `mem[load_addr]`=`load_data`. `start`=1 moves to STEP. `load_en` and `start` in the same cycle: the write completes and start is taken.
- STEP: `pc_en`=1 for exactly one cycle, then READ.
- READ: `instr` <= `mem[pc]`, `instr_valid` <= 1, then OUT.
- OUT: `instr`/`instr_valid` held stable until `instr_valid & instr_ready`. On handshake, `instr_valid` <= 0, and:
  - opcode == `HALT_OP` -> HALT;
  - else `pc` == 2^ADDR_W-1 -> HALT (no wrap to 0);
  - else -> STEP.
- HALT: `halted`=1, `pc_en`=0, `instr_valid`=0. Exit only via reset. `start` and `load_en` are ignored.
- `load_en` outside IDLE: ignored, memory unchanged.
- Integration: this block never resets the counter. The counter must be at 2^ADDR_W-1 (its reset value) when `start` is taken, so that the first STEP yields address 0.

## Timing
- Reset (`res`=0 at an edge) sets state IDLE, `pc_en`=0, `instr`=0, `instr_valid`=0, `halted`=0, `busy`=0. Memory contents are retained.
- Reset mid-operation, including while `instr_valid` is high: the outputs above take their reset values at that edge, and the pending instruction is dropped.
- `start` sampled at edge k:
  - STEP during cycle k..k+1, with `pc_en` high;
  - counter advances at edge k+1;
  - READ during k+1..k+2;
  - `instr_valid`=1 from edge k+2.
  - Start-to-valid latency is 2 cycles after the start edge.
- Handshake at edge h gives the next `instr_valid` at edge h+2. Maximum throughput is one instruction per 3 cycles with `instr_ready` tied high.
- Memory: synchronous write; read registered into `instr`. A write at edge k is visible to a READ at edge k+1 or later.
- `pc_en` is a registered state decode, so there is no combinational path from `instr_ready` or `start`.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`, `DATA_W`, `HALT_OP`, opcode field position, and the fetch state enum (IDLE/STEP/READ/OUT/HALT).
- Sub-module `instr_mem`: 2^ADDR_W x DATA_W, one synchronous write port and one registered read port; no reset on the array.
- `instr_fetch` contains the FSM, the output registers and the halt detection.

## Test plan
- Load `mem[0..2]`=16'h1234, 16'h2345, 16'hF000; reset the counter to 63; pulse `start`; `instr_ready`=1. Expected: `instr` sequence 1234, 2345, F000, then `halted`=1 and `pc`=2, with exactly 3 `pc_en` pulses.
- Backpressure: `instr_ready`=0 for 5 cycles after `instr_valid` rises. Expected: `instr` stable, no `pc_en` pulse; handshake on ready, next valid 2 edges later.
- End of memory: fill all 64 words with non-HALT values; run to completion. Expected: 64 instructions accepted, `halted`=1 after address 63, counter not advanced past 63.
- Load while busy: `load_en` to address 5 during OUT. Expected: `mem[5]` unchanged, confirmed by reading address 5 on a later fetch.
- Reset mid-operation: `res`=0 for 1 cycle during OUT with `instr_valid`=1. Expected: next cycle `instr_valid`=0, `instr`=0, `busy`=0, `halted`=0, memory intact.
- Same-cycle events: `start` and `load_en` (addr 0, data 16'hABCD) together in IDLE. Expected: first fetched `instr`=ABCD.
